// File: rtl/dp_pkg.sv
// Shared encodings for the sequential datapath: opcodes, ALU ops, shifts and FSM states.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ALU  = 3'b010,
        OP_CMP  = 3'b011
    } op_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    // Opcodes 1xx are reserved and must not touch any state.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: one synchronous write port, two combinational read ports, synchronous active-low clear.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic [W-1:0]            i_wdata,
    input  logic [$clog2(NREG)-1:0] i_raddr_a,
    output logic [W-1:0]            o_rdata_a,
    input  logic [$clog2(NREG)-1:0] i_raddr_b,
    output logic [W-1:0]            o_rdata_b
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle register datapath: IDLE -> RDA -> RDB -> EXEC -> WB command sequencer around dp_regfile.
// Define DATAPATH_SEQ_OVF_EN to build signed-overflow detection into the V status bit.
module datapath_seq
    import dp_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [1:0]              cmd_alu,
    input  logic [1:0]              cmd_shift,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rn,
    input  logic [$clog2(NREG)-1:0] cmd_rm,
    input  logic [W-1:0]            cmd_imm,
    output logic                    done,
    output logic [W-1:0]            result,
    output logic [2:0]              status,
    output logic [2:0]              o_dbg_state
);

    localparam int AW = $clog2(NREG);

    state_e          r_state;
    state_e          w_next;
    logic            w_ready;
    logic            w_accept;
    logic            w_rf_we;

    logic [2:0]      r_op;
    logic [1:0]      r_alu;
    logic [1:0]      r_shift;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_rn;
    logic [AW-1:0]   r_rm;
    logic [W-1:0]    r_imm;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [2:0]      r_status;
    logic            r_done;

    logic [W-1:0]    w_rd_a;
    logic [W-1:0]    w_rd_b;
    logic [W-1:0]    w_b_sh;
    logic [W-1:0]    w_alu;
    logic            w_ovf;
    logic [2:0]      w_flags;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high.
    assign w_accept = cmd_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_rf_we = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = reset_n;
                if (w_accept) begin
                    if (!is_legal_op(cmd_op)) begin
                        w_next = ST_WB;
                    end else if (cmd_op == OP_MOVI) begin
                        w_next = ST_EXEC;
                    end else begin
                        w_next = ST_RDA;
                    end
                end
            end
            ST_RDA:  w_next = ST_RDB;
            ST_RDB:  w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB: begin
                w_next  = ST_IDLE;
                w_rf_we = (r_op == OP_MOVI) || (r_op == OP_MOV) || (r_op == OP_ALU);
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_b_sh = r_b;
        case (r_shift)
            SH_NONE: w_b_sh = r_b;
            SH_LSL1: w_b_sh = {r_b[W-2:0], 1'b0};
            SH_LSR1: w_b_sh = {1'b0, r_b[W-1:1]};
            SH_ASR1: w_b_sh = {r_b[W-1], r_b[W-1:1]};
            default: w_b_sh = r_b;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (r_alu)
            ALU_ADD:  w_alu = r_a + w_b_sh;
            ALU_SUB:  w_alu = r_a - w_b_sh;
            ALU_AND:  w_alu = r_a & w_b_sh;
            ALU_NOTB: w_alu = ~w_b_sh;
            default:  w_alu = '0;
        endcase
    end

`ifdef DATAPATH_SEQ_OVF_EN
    // Subtraction overflows when the operand signs differ (i.e. A and ~B agree) and the result flips sign.
    always_comb begin
        w_ovf = 1'b0;
        case (r_alu)
            ALU_ADD: w_ovf = (r_a[W-1] == w_b_sh[W-1]) && (w_alu[W-1] != r_a[W-1]);
            ALU_SUB: w_ovf = (r_a[W-1] != w_b_sh[W-1]) && (w_alu[W-1] != r_a[W-1]);
            default: w_ovf = 1'b0;
        endcase
    end
`else
    assign w_ovf = 1'b0;
`endif

    assign w_flags = {(w_alu == '0), w_alu[W-1], w_ovf};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_alu    <= '0;
            r_shift  <= '0;
            r_rd     <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_next == ST_WB);
            if (w_accept) begin
                r_op    <= cmd_op;
                r_alu   <= cmd_alu;
                r_shift <= cmd_shift;
                r_rd    <= cmd_rd;
                r_rn    <= cmd_rn;
                r_rm    <= cmd_rm;
                r_imm   <= cmd_imm;
            end
            case (r_state)
                ST_RDA: r_a <= w_rd_a;
                ST_RDB: r_b <= w_rd_b;
                ST_EXEC: begin
                    if (r_op == OP_MOVI) begin
                        r_c <= r_imm;
                    end else if (r_op == OP_MOV) begin
                        r_c <= w_b_sh;
                    end else begin
                        r_c      <= w_alu;
                        r_status <= w_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    dp_regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_rf (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_we      (w_rf_we),
        .i_waddr   (r_rd),
        .i_wdata   (r_c),
        .i_raddr_a (r_rn),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (r_rm),
        .o_rdata_b (w_rd_b)
    );

    assign cmd_ready   = w_ready;
    assign done        = r_done;
    assign result      = r_c;
    assign status      = r_status;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: one 16-bit/8-register and one 8-bit/4-register instance, run in turn.
module tb_datapath_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_alu;
    logic [1:0]  cmd_shift;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rn;
    logic [2:0]  cmd_rm;
    logic [15:0] cmd_imm;

    logic        ready16, done16, ready8, done8;
    logic [15:0] result16;
    logic [7:0]  result8;
    logic [2:0]  status16, status8, dbg16, dbg8;

    logic        obs_ready, obs_done;
    logic [15:0] obs_result;
    logic [2:0]  obs_status, obs_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_res_q[$];
    logic [2:0]  exp_st_q[$];
    int          exp_lat_q[$];

    datapath_seq #(.W(16), .NREG(8)) dut16 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(ready16),
        .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_shift(cmd_shift),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
        .done(done16), .result(result16), .status(status16), .o_dbg_state(dbg16)
    );

    datapath_seq #(.W(8), .NREG(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & sel), .cmd_ready(ready8),
        .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_shift(cmd_shift),
        .cmd_rd(cmd_rd[1:0]), .cmd_rn(cmd_rn[1:0]), .cmd_rm(cmd_rm[1:0]), .cmd_imm(cmd_imm[7:0]),
        .done(done8), .result(result8), .status(status8), .o_dbg_state(dbg8)
    );

    always_comb begin
        obs_ready  = sel ? ready8 : ready16;
        obs_done   = sel ? done8 : done16;
        obs_result = sel ? {8'h00, result8} : result16;
        obs_status = sel ? status8 : status16;
        obs_dbg    = sel ? dbg8 : dbg16;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (W=%0d): observed %h expected %h", tag, sel ? 8 : 16, obs, exp);
        end
    endtask

    task automatic scramble();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_alu   = 2'($urandom_range(0, 3));
        cmd_shift = 2'($urandom_range(0, 3));
        cmd_rd    = 3'($urandom_range(0, 7));
        cmd_rn    = 3'($urandom_range(0, 7));
        cmd_rm    = 3'($urandom_range(0, 7));
        cmd_imm   = 16'($urandom_range(0, 65535));
    endtask

    task automatic set_fields(input logic [2:0] op, input logic [1:0] alu, input logic [1:0] sh,
                              input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                              input logic [15:0] imm);
        cmd_op    = op;
        cmd_alu   = alu;
        cmd_shift = sh;
        cmd_rd    = rd;
        cmd_rn    = rn;
        cmd_rm    = rm;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
    endtask

    task automatic start_cmd(input logic [2:0] op, input logic [1:0] alu, input logic [1:0] sh,
                             input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                             input logic [15:0] imm, input logic [15:0] res,
                             input logic [2:0] st, input int lat);
        set_fields(op, alu, sh, rd, rn, rm, imm);
        exp_res_q.push_back(res);
        exp_st_q.push_back(st);
        exp_lat_q.push_back(lat);
    endtask

    task automatic wait_accept(input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (obs_ready) ok = 1'b1;
        end
        chk({tag, "_accept"}, {15'd0, ok}, 16'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int          lat = 0;
        logic [15:0] er;
        logic [2:0]  es;
        int          el;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (obs_done) lat = k;
        end
        er = exp_res_q.pop_front();
        es = exp_st_q.pop_front();
        el = exp_lat_q.pop_front();
        chk({tag, "_lat"}, 16'(lat), 16'(el));
        chk({tag, "_result"}, obs_result, er);
        chk({tag, "_status"}, 16'(obs_status), 16'(es));
        @(negedge clk);
        chk({tag, "_pulse"}, {15'd0, obs_done}, 16'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] alu,
                           input logic [1:0] sh, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [15:0] imm,
                           input logic [15:0] res, input logic [2:0] st, input int lat);
        start_cmd(op, alu, sh, rd, rn, rm, imm, res, st, lat);
        wait_accept(tag);
        scramble();
        wait_done(tag);
    endtask

    // Register contents are observed by moving a register onto itself and reading C.
    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] val,
                             input logic [2:0] st);
        run_cmd(tag, 3'b001, 2'b00, 2'b00, idx, idx, idx, 16'h0000, val, st, 4);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", {15'd0, obs_ready}, 16'd1);
        chk("rst_done", {15'd0, obs_done}, 16'd0);
        chk("rst_result", obs_result, 16'h0000);
        chk("rst_status", 16'(obs_status), 16'h0000);
        chk("rst_state", 16'(obs_dbg), 16'h0000);
    endtask

    task automatic run_suite(input logic s);
        logic [15:0] v_hi  = s ? 16'h0034 : 16'h1234;
        logic [15:0] v_max = s ? 16'h007F : 16'h7FFF;
        logic [15:0] v_msb = s ? 16'h0080 : 16'h8000;
        logic [15:0] v_src = s ? 16'h0082 : 16'h8002;
        logic [15:0] v_asr = s ? 16'h00C1 : 16'hC001;
        logic [15:0] v_lsr = s ? 16'h0041 : 16'h4001;
        logic [15:0] v_nb  = s ? 16'h00FB : 16'hFFFB;
`ifdef DATAPATH_SEQ_OVF_EN
        logic [2:0]  st_add = 3'b011;
`else
        logic [2:0]  st_add = 3'b010;
`endif
        logic        seen;
        sel = s;
        do_reset();

        run_cmd("movi_r3", 3'b000, 2'b00, 2'b00, 3'd3, 3'd0, 3'd0, v_hi, v_hi, 3'b000, 2);
        check_reg("r3", 3'd3, v_hi, 3'b000);

        run_cmd("movi_r1", 3'b000, 2'b00, 2'b00, 3'd1, 3'd0, 3'd0, v_max, v_max, 3'b000, 2);
        run_cmd("movi_r2", 3'b000, 2'b00, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 3'b000, 2);
        run_cmd("add_r0", 3'b010, 2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 16'h0000, v_msb, st_add, 4);
        check_reg("r0", 3'd0, v_msb, st_add);

        run_cmd("movi_r4", 3'b000, 2'b00, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0005, 16'h0005, st_add, 2);
        run_cmd("cmp_r4", 3'b011, 2'b01, 2'b00, 3'd2, 3'd4, 3'd4, 16'h0000, 16'h0000, 3'b100, 4);
        check_reg("r4", 3'd4, 16'h0005, 3'b100);
        check_reg("cmp_nowr", 3'd2, 16'h0001, 3'b100);

        run_cmd("movi_r5", 3'b000, 2'b00, 2'b00, 3'd5, 3'd0, 3'd0, v_src, v_src, 3'b100, 2);
        run_cmd("mov_asr", 3'b001, 2'b00, 2'b11, 3'd6, 3'd0, 3'd5, 16'h0000, v_asr, 3'b100, 4);
        run_cmd("mov_lsr", 3'b001, 2'b00, 2'b10, 3'd7, 3'd0, 3'd5, 16'h0000, v_lsr, 3'b100, 4);
        check_reg("r6", 3'd6, v_asr, 3'b100);
        check_reg("r7", 3'd7, v_lsr, 3'b100);
        run_cmd("notb_lsl", 3'b010, 2'b11, 2'b01, 3'd0, 3'd3, 3'd5, 16'h0000, v_nb, 3'b010, 4);

        // Back-to-back with cmd_valid held high; second command reads the register just written.
        start_cmd(3'b000, 2'b00, 2'b00, 3'd1, 3'd0, 3'd0, 16'h00A5, 16'h00A5, 3'b010, 2);
        wait_accept("b2b_1");
        start_cmd(3'b001, 2'b00, 2'b00, 3'd2, 3'd0, 3'd1, 16'h0000, 16'h00A5, 3'b010, 4);
        wait_done("b2b_1");
        chk("b2b_gap_ready", {15'd0, obs_ready}, 16'd1);
        @(posedge clk);
        #1;
        scramble();
        wait_done("b2b_2");

        run_cmd("illegal", 3'b110, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h00FF, 16'h00A5, 3'b010, 1);
        check_reg("ill_nowr", 3'd0, v_nb, 3'b010);

        // Reset asserted while an ALU command sits in RDB.
        set_fields(3'b010, 2'b00, 2'b00, 3'd3, 3'd1, 3'd1, 16'h0000);
        wait_accept("rst_mid");
        scramble();
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_rdb", 16'(obs_dbg), 16'h0002);
        reset_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | obs_done;
        end
        reset_n = 1'b1;
        #1;
        chk("rst_mid_ready", {15'd0, obs_ready}, 16'd1);
        repeat (5) begin
            @(negedge clk);
            seen = seen | obs_done;
        end
        chk("rst_mid_nodone", {15'd0, seen}, 16'd0);
        chk("rst_mid_result", obs_result, 16'h0000);
        chk("rst_mid_status", 16'(obs_status), 16'h0000);
        check_reg("rst_mid_rd", 3'd3, 16'h0000, 3'b000);
        check_reg("rst_mid_r1", 3'd1, 16'h0000, 3'b000);
    endtask

    initial begin
        reset_n = 1'b0;
        sel     = 1'b0;
        scramble();
        run_suite(1'b0);
        run_suite(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
